// File: rtl/sort_sched.sv
// rtl/sort_sched.sv - round-robin scheduler sharing one combinational sort unit
//
// Purpose: grants one of NREQ requesters at a time (round-robin from r_ptr),
// registers its operand onto the sort unit input, captures the sort result one
// cycle later and returns it tagged with the requester id over a valid/ready
// response channel.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   req_valid    per-requester operand valid
//   req_data     operands, requester i at [i*W +: W]
//   req_ready    one-hot accept strobe (IDLE only, combinational)
//   sort_in      registered operand to the sort unit
//   sort_out     combinational result from the sort unit
//   rsp_valid/rsp_ready/rsp_id/rsp_data   response channel
//   busy         high whenever the FSM is not IDLE
//   done_cnt     completed-response counter, wraps
module sort_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      sort_in,
  input  logic [W-1:0]      sort_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              busy,
  output logic [CNTW-1:0]   done_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [IDW-1:0]  r_rsp_id;
  logic [W-1:0]    r_sort_in;
  logic [W-1:0]    r_rsp_data;
  logic            r_rsp_valid;
  logic [CNTW-1:0] r_done_cnt;

  logic            w_found;
  logic [IDW-1:0]  w_grant;
  logic [W-1:0]    w_grant_data;
  logic [IDW-1:0]  w_ptr_nxt;
  logic            w_accept;

  // Cyclic priority scan starting at r_ptr; the first valid requester wins.
  always_comb begin
    int idx;
    idx          = 0;
    w_found      = 1'b0;
    w_grant      = '0;
    w_grant_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found      = 1'b1;
        w_grant      = IDW'(idx);
        w_grant_data = req_data[idx*W +: W];
      end
    end
  end

  assign w_accept  = (r_state == S_RESP) && rsp_ready;
  // Next search starts just after the requester that was served.
  assign w_ptr_nxt = (r_rsp_id == IDW'(NREQ - 1)) ? '0 : r_rsp_id + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_EVAL;
      S_EVAL:  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_rsp_id    <= '0;
      r_sort_in   <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      // sort_in only moves on the grant edge so the sort unit sees a
      // stable operand through EVAL and RESP.
      if (r_state == S_IDLE && w_found) begin
        r_sort_in <= w_grant_data;
        r_id      <= w_grant;
      end
      if (r_state == S_EVAL) begin
        r_rsp_data  <= sort_out;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end
      if (w_accept) begin
        r_rsp_valid <= 1'b0;
        r_ptr       <= w_ptr_nxt;
        r_done_cnt  <= r_done_cnt + 1'b1;
      end
    end
  end

  assign req_ready = (r_state == S_IDLE && w_found) ? (NREQ'(1) << w_grant) : '0;
  assign sort_in   = r_sort_in;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != S_IDLE);
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_sort_sched.sv
// tb/tb_sort_sched.sv - directed self-checking bench for sort_sched
module tb_sort_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  sort_in;
  logic [7:0]  sort_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;
  logic [15:0] done_cnt;

  // Second instance with a narrow counter to exercise the wrap.
  logic        w_rst_n;
  logic [3:0]  w_req_valid;
  logic [31:0] w_req_data;
  logic [3:0]  w_req_ready;
  logic [7:0]  w_sort_in;
  logic [7:0]  w_sort_out;
  logic        w_rsp_valid;
  logic        w_rsp_ready;
  logic [1:0]  w_rsp_id;
  logic [7:0]  w_rsp_data;
  logic        w_busy;
  logic [3:0]  w_done_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Sort unit model: sorts the operand's bits so all ones move to the MSBs.
  function automatic logic [7:0] gold(input logic [7:0] x);
    logic [7:0] full;
    int n;
    full = 8'hFF;
    n = $countones(x);
    return ~(full >> n);
  endfunction

  assign sort_out   = gold(sort_in);
  assign w_sort_out = gold(w_sort_in);

  sort_sched #(.NREQ(4), .W(8), .IDW(2), .CNTW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .sort_in(sort_in), .sort_out(sort_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy), .done_cnt(done_cnt)
  );

  sort_sched #(.NREQ(4), .W(8), .IDW(2), .CNTW(4)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .req_valid(w_req_valid), .req_data(w_req_data),
    .req_ready(w_req_ready), .sort_in(w_sort_in), .sort_out(w_sort_out),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_id(w_rsp_id),
    .rsp_data(w_rsp_data), .busy(w_busy), .done_cnt(w_done_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b0; req_data = 32'h0; rsp_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0) begin n_errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    n_checks++; if (sort_in !== 8'h00) begin n_errors++; $display("FAIL reset_sort_in got %h exp 00", sort_in); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd0) begin n_errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
    n_checks++; if (rsp_data !== 8'h00) begin n_errors++; $display("FAIL reset_rsp_data got %h exp 00", rsp_data); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (done_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_done_cnt got %h exp 0000", done_cnt); end
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_data  = 32'h00A5_0000;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL single_req_ready got %b exp 0100", req_ready); end
    step();
    req_valid = 4'b0;
    n_checks++; if (sort_in !== 8'hA5) begin n_errors++; $display("FAIL single_sort_in got %h exp a5", sort_in); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL single_eval_valid got %b exp 0", rsp_valid); end
    step();
    n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL single_rsp_valid got %b exp 1", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd2) begin n_errors++; $display("FAIL single_rsp_id got %0d exp 2", rsp_id); end
    n_checks++; if (rsp_data !== 8'hF0) begin n_errors++; $display("FAIL single_rsp_data got %h exp f0", rsp_data); end
    step();
    n_checks++; if (done_cnt !== 16'd1) begin n_errors++; $display("FAIL single_done_cnt got %0d exp 1", done_cnt); end
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_errors++; $display("FAIL single_idle got busy=%b valid=%b exp 0 0", busy, rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_op [4];
    logic [7:0] exp_res [4];
    logic [3:0] exp_rdy;
    int id;
    exp_op[0] = 8'hFE; exp_res[0] = 8'hFE;
    exp_op[1] = 8'h07; exp_res[1] = 8'hE0;
    exp_op[2] = 8'h81; exp_res[2] = 8'hC0;
    exp_op[3] = 8'h3C; exp_res[3] = 8'hF0;
    rst_n = 1'b0; req_valid = 4'b0; step(); rst_n = 1'b1;
    req_data  = 32'h3C81_07FE;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      id = i % 4;
      exp_rdy = 4'b0001 << id;
      #1;
      n_checks++; if (req_ready !== exp_rdy) begin n_errors++; $display("FAIL rr_req_ready op %0d got %b exp %b", i, req_ready, exp_rdy); end
      step();
      n_checks++; if (sort_in !== exp_op[id]) begin n_errors++; $display("FAIL rr_sort_in op %0d got %h exp %h", i, sort_in, exp_op[id]); end
      step();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(id)) begin n_errors++; $display("FAIL rr_rsp op %0d got valid=%b id=%0d exp 1 %0d", i, rsp_valid, rsp_id, id); end
      n_checks++; if (rsp_data !== exp_res[id]) begin n_errors++; $display("FAIL rr_rsp_data op %0d got %h exp %h", i, rsp_data, exp_res[id]); end
      step();
    end
    n_checks++; if (done_cnt !== 16'd5) begin n_errors++; $display("FAIL rr_done_cnt got %0d exp 5", done_cnt); end
  endtask

  task automatic test_stall();
    // ptr is now 1 after requester 0 was served last.
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'hE0) begin n_errors++; $display("FAIL stall_hold cyc %0d got valid=%b id=%0d data=%h exp 1 1 e0", i, rsp_valid, rsp_id, rsp_data); end
      n_checks++; if (req_ready !== 4'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL stall_ready cyc %0d got ready=%b busy=%b exp 0000 1", i, req_ready, busy); end
      step();
    end
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_errors++; $display("FAIL stall_release got busy=%b valid=%b exp 0 0", busy, rsp_valid); end
    n_checks++; if (done_cnt !== 16'd6) begin n_errors++; $display("FAIL stall_done_cnt got %0d exp 6", done_cnt); end
  endtask

  task automatic test_reset_in_eval();
    req_data  = 32'h00A5_0000;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rst_eval_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL rst_eval_idle got valid=%b busy=%b exp 0 0", rsp_valid, busy); end
    n_checks++; if (done_cnt !== 16'd0 || sort_in !== 8'h00) begin n_errors++; $display("FAIL rst_eval_regs got cnt=%0d sort_in=%h exp 0 00", done_cnt, sort_in); end
    step();
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_eval_no_pulse got %b exp 0", rsp_valid); end
    req_data  = 32'h1122_3355;
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL rst_eval_ptr got %b exp 0001", req_ready); end
    step();
    req_valid = 4'b0;
    step();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'hF0) begin n_errors++; $display("FAIL rst_eval_rsp got valid=%b id=%0d data=%h exp 1 0 f0", rsp_valid, rsp_id, rsp_data); end
    step();
    n_checks++; if (done_cnt !== 16'd1) begin n_errors++; $display("FAIL rst_eval_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_wrap();
    w_rst_n = 1'b0; w_req_valid = 4'b0; w_req_data = 32'h0000_00FF; w_rsp_ready = 1'b1;
    step();
    w_rst_n = 1'b1;
    w_req_valid = 4'b0001;
    repeat (45) step();
    n_checks++; if (w_done_cnt !== 4'hF) begin n_errors++; $display("FAIL wrap_full got %h exp f", w_done_cnt); end
    n_checks++; if (w_busy !== 1'b0) begin n_errors++; $display("FAIL wrap_idle got %b exp 0", w_busy); end
    repeat (3) step();
    n_checks++; if (w_done_cnt !== 4'h0) begin n_errors++; $display("FAIL wrap_zero got %h exp 0", w_done_cnt); end
    w_req_valid = 4'b0;
  endtask

  initial begin
    w_rst_n = 1'b0; w_req_valid = 4'b0; w_req_data = 32'h0; w_rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_in_eval();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
